// File: rtl/instruction_fetch_unit.sv
// Fetch stage for the 16-bit multicycle CPU: owns the PC, fetches one word over req/ack, strobes the IR.
// Optional fetch timeout with sticky fault is compiled in with FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_start,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic [15:0] o_instr,
  output logic        o_ir_write,
  output logic [15:0] o_pc,
  output logic        o_busy,
  output logic        o_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout_cycles
    $error("instruction_fetch_unit: TIMEOUT_CYCLES must be 1..255");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] w_mem_addr_nxt;
  logic [15:0] r_instr;
  logic [15:0] w_instr_nxt;
  logic [15:0] r_pend_pc;
  logic [15:0] w_pend_pc_nxt;
  logic        r_mem_req;
  logic        w_mem_req_nxt;
  logic        r_ir_write;
  logic        w_ir_write_nxt;
  logic        r_pend;
  logic        w_pend_nxt;
  logic        r_busy;
  logic        r_fault;
  logic        w_fault_nxt;
  logic        w_timeout;
  logic        w_start_ok;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  // Wait counter: zero outside REQ, so it is already clear on entry to REQ.
  always_comb begin
    w_cnt_nxt = 8'd0;
    w_timeout = 1'b0;
    if ((r_state == ST_REQ) && !i_mem_ack) begin
      if (r_cnt == TIMEOUT_LAST) begin
        w_timeout = 1'b1;
        w_cnt_nxt = 8'd0;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
    end else begin
      w_cnt_nxt = 8'd0;
    end
  end

  // Wait counter register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign w_start_ok = ~r_fault;
`else
  assign w_timeout  = 1'b0;
  assign w_start_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_mem_addr_nxt = r_mem_addr;
    w_instr_nxt    = r_instr;
    w_pend_pc_nxt  = r_pend_pc;
    w_mem_req_nxt  = r_mem_req;
    w_ir_write_nxt = 1'b0;
    w_pend_nxt     = r_pend;
    w_fault_nxt    = r_fault;
    case (r_state)
      ST_IDLE: begin
        if (i_redirect) begin
          w_pc_nxt = i_redirect_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (i_fetch_start && w_start_ok) begin
          w_mem_addr_nxt = i_redirect ? i_redirect_pc : r_pc;
          w_mem_req_nxt  = 1'b1;
          w_state_nxt    = ST_REQ;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_redirect) begin
          w_pend_nxt    = 1'b1;
          w_pend_pc_nxt = i_redirect_pc;
        end else begin
          w_pend_nxt    = r_pend;
        end
        if (i_mem_ack) begin
          w_instr_nxt    = i_mem_rdata;
          w_mem_req_nxt  = 1'b0;
          w_ir_write_nxt = 1'b1;
          w_state_nxt    = ST_DONE;
          // A redirect seen at any point in this fetch replaces the sequential PC.
          if (r_pend || i_redirect) begin
            w_pc_nxt = r_pc;
          end else begin
            w_pc_nxt = r_mem_addr + 16'd1;
          end
        end else if (w_timeout) begin
          w_mem_req_nxt = 1'b0;
          w_fault_nxt   = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_state_nxt   = ST_REQ;
        end
      end
      ST_DONE: begin
        if (i_redirect) begin
          w_pc_nxt = i_redirect_pc;
        end else if (r_pend) begin
          w_pc_nxt = r_pend_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
        w_pend_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_pend_nxt    = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_instr    <= 16'h0000;
      r_pend_pc  <= 16'h0000;
      r_mem_req  <= 1'b0;
      r_ir_write <= 1'b0;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_instr    <= w_instr_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_ir_write <= w_ir_write_nxt;
      r_pend     <= w_pend_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_fault    <= w_fault_nxt;
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_instr    = r_instr;
  assign o_ir_write = r_ir_write;
  assign o_pc       = r_pc;
  assign o_busy     = r_busy;
  assign o_fault    = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed literal checks plus random traffic against a fetch-level model.
module tb_instruction_fetch_unit;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int TMO = 4;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_STROBE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fs, rd, ack;
  logic [15:0] rpc, rdata;
  logic        mem_req, ir_write, busy, fault;
  logic [15:0] mem_addr, instr, pc;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk), .i_reset(rst), .i_fetch_start(fs), .i_redirect(rd), .i_redirect_pc(rpc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(ack), .i_mem_rdata(rdata),
    .o_instr(instr), .o_ir_write(ir_write), .o_pc(pc), .o_busy(busy), .o_fault(fault)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fetch-level reference model
  bit          m_valid = 1'b0;
  int          m_phase, m_waited;
  logic [15:0] m_pc, m_addr, m_instr, m_pend_pc;
  logic        m_req, m_irw, m_fault, m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_phase = P_IDLE; m_waited = 0;
      m_pc = RST_PC; m_addr = RST_PC; m_instr = 16'h0000; m_pend_pc = 16'h0000;
      m_req = 1'b0; m_irw = 1'b0; m_fault = 1'b0; m_pend = 1'b0;
    end else begin
      m_irw = 1'b0;
      case (m_phase)
        P_IDLE: begin
          if (rd) m_pc = rpc;
          if (fs && !m_fault) begin
            m_addr = m_pc; m_req = 1'b1; m_phase = P_WAIT; m_waited = 0;
          end
        end
        P_WAIT: begin
          if (rd) begin m_pend = 1'b1; m_pend_pc = rpc; end
          if (ack) begin
            m_instr = rdata; m_req = 1'b0; m_irw = 1'b1; m_phase = P_STROBE;
            if (!m_pend) m_pc = m_addr + 16'd1;
          end else if (TIMEOUT_ON) begin
            m_waited++;
            if (m_waited == TMO) begin m_req = 1'b0; m_fault = 1'b1; m_phase = P_IDLE; end
          end
        end
        default: begin
          if (rd) m_pc = rpc;
          else if (m_pend) m_pc = m_pend_pc;
          m_pend = 1'b0; m_phase = P_IDLE;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("mem_req", {15'd0, mem_req}, {15'd0, m_req});
      chk("mem_addr", mem_addr, m_addr);
      chk("instr", instr, m_instr);
      chk("ir_write", {15'd0, ir_write}, {15'd0, m_irw});
      chk("busy", {15'd0, busy}, {15'd0, (m_phase != P_IDLE)});
      chk("fault", {15'd0, fault}, {15'd0, m_fault});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; rd = 1'b0; ack = 1'b0; rpc = 16'h0000; rdata = 16'h0000;
    step(); step();
    rst = 1'b0;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_irw", {15'd0, ir_write}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);

    // Basic fetch, ack three cycles after start
    fs = 1'b1; step(); fs = 1'b0;
    chk("t2_req", {15'd0, mem_req}, 16'd1);
    chk("t2_addr", mem_addr, 16'h0000);
    step(); step();
    ack = 1'b1; rdata = 16'h1A2B; step(); ack = 1'b0;
    chk("t2_irw", {15'd0, ir_write}, 16'd1);
    chk("t2_instr", instr, 16'h1A2B);
    chk("t2_pc", pc, 16'h0001);
    step();
    chk("t2_irw_off", {15'd0, ir_write}, 16'd0);
    chk("t2_idle", {15'd0, busy}, 16'd0);

    // PC wrap at FFFF
    rd = 1'b1; rpc = 16'hFFFF; step(); rd = 1'b0;
    chk("t3_pc", pc, 16'hFFFF);
    fs = 1'b1; step(); fs = 1'b0;
    chk("t3_addr", mem_addr, 16'hFFFF);
    ack = 1'b1; rdata = 16'hBEEF; step(); ack = 1'b0;
    chk("t3_wrap", pc, 16'h0000);
    chk("t3_instr", instr, 16'hBEEF);
    step();

    // Redirect during REQ
    fs = 1'b1; step(); fs = 1'b0;
    rd = 1'b1; rpc = 16'h0040; step(); rd = 1'b0;
    step();
    ack = 1'b1; rdata = 16'hC0DE; step(); ack = 1'b0;
    chk("t4_instr", instr, 16'hC0DE);
    chk("t4_old_addr", mem_addr, 16'h0000);
    step();
    chk("t4_pc", pc, 16'h0040);
    fs = 1'b1; step(); fs = 1'b0;
    chk("t4_addr", mem_addr, 16'h0040);
    ack = 1'b1; rdata = 16'h1234; step(); ack = 1'b0;
    step();
    chk("t4_pc_next", pc, 16'h0041);

    // Reset mid-fetch, late ack ignored
    fs = 1'b1; step(); fs = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_req", {15'd0, mem_req}, 16'd0);
    chk("t5_pc", pc, RST_PC);
    ack = 1'b1; rdata = 16'hDEAD; step(); ack = 1'b0;
    chk("t5_irw", {15'd0, ir_write}, 16'd0);
    chk("t5_instr", instr, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(63) == 0);
      fs    = ($urandom_range(2) == 0);
      rd    = ($urandom_range(4) == 0);
      rpc   = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      ack   = ($urandom_range(4) < 2);
      rdata = 16'($urandom);
      step();
    end
    rst = 1'b1; fs = 1'b0; rd = 1'b0; ack = 1'b0; step(); rst = 1'b0;

    // Fetch with no ack
    fs = 1'b1; step(); fs = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      chk("t6_req_held", {15'd0, mem_req}, 16'd1);
      step();
    end
    chk("t6_req_drop", {15'd0, mem_req}, 16'd0);
    chk("t6_fault", {15'd0, fault}, 16'd1);
    chk("t6_irw", {15'd0, ir_write}, 16'd0);
    fs = 1'b1; step(); fs = 1'b0; step();
    chk("t6_ignored", {15'd0, mem_req}, 16'd0);
    chk("t6_sticky", {15'd0, fault}, 16'd1);
`else
    for (int i = 0; i < 20; i++) begin
      chk("t6_req_held", {15'd0, mem_req}, 16'd1);
      step();
    end
    ack = 1'b1; rdata = 16'h5A5A; step(); ack = 1'b0;
    chk("t6_irw", {15'd0, ir_write}, 16'd1);
    chk("t6_no_fault", {15'd0, fault}, 16'd0);
`endif
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
